// File: rtl/time_counter.sv
// Timekeeping core: hh:mm:ss counter on clk_1Hz with a midnight day_tick pulse.
// UI state bus is shared with the date block; only states 2-4 (time set) freeze the clock.
//
//   state | meaning
//   0     | RUN        - counting
//   1     | SHOW_DATE  - counting
//   2     | SET_SECOND - frozen, press clears seconds
//   3     | SET_MINUTE - frozen, press increments minutes (no carry)
//   4     | SET_HOUR   - frozen, press increments hours (no day_tick)
//   5-7   | date-set   - counting, owned by the date block
module time_counter #(
  parameter int hour_num  = 5,
  parameter int min_num   = 6,
  parameter int sec_num   = 6,
  parameter int state_num = 8,
  parameter int hour_max  = 24
) (
  input  logic                         clk_1Hz,
  input  logic                         rst_n,
  input  logic [$clog2(state_num)-1:0] state,
  input  logic                         set_button,
  output logic [sec_num-1:0]           seconds,
  output logic [min_num-1:0]           minutes,
  output logic [hour_num-1:0]          hours,
  output logic                         day_tick,
  output logic                         setting
);

  localparam int state_w = $clog2(state_num);

  localparam logic [state_w-1:0]  st_set_sec  = state_w'(2);
  localparam logic [state_w-1:0]  st_set_min  = state_w'(3);
  localparam logic [state_w-1:0]  st_set_hour = state_w'(4);

  localparam logic [sec_num-1:0]  sec_last  = sec_num'(59);
  localparam logic [min_num-1:0]  min_last  = min_num'(59);
  localparam logic [hour_num-1:0] hour_last = hour_num'(hour_max - 1);

  logic btn_s1, btn_s2, btn_s2_d;
  logic press;

  logic [sec_num-1:0]  sec_nxt;
  logic [min_num-1:0]  min_nxt;
  logic [hour_num-1:0] hour_nxt;
  logic                tick_nxt;

  // Button idles high; synchronizer flops reset to the released level so reset never fakes a press.
  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1   <= 1'b1;
      btn_s2   <= 1'b1;
      btn_s2_d <= 1'b1;
    end else begin
      btn_s1   <= set_button;
      btn_s2   <= btn_s1;
      btn_s2_d <= btn_s2;
    end
  end

  assign press   = btn_s2_d & ~btn_s2;
  assign setting = (state == st_set_sec) || (state == st_set_min) || (state == st_set_hour);

  always_comb begin
    sec_nxt  = seconds;
    min_nxt  = minutes;
    hour_nxt = hours;
    tick_nxt = 1'b0;
    case (state)
      st_set_sec: begin
        if (press) sec_nxt = '0;
      end
      st_set_min: begin
        if (press) min_nxt = (minutes == min_last) ? '0 : minutes + min_num'(1);
      end
      st_set_hour: begin
        if (press) hour_nxt = (hours == hour_last) ? '0 : hours + hour_num'(1);
      end
      default: begin
        if (seconds == sec_last) begin
          sec_nxt = '0;
          if (minutes == min_last) begin
            min_nxt = '0;
            if (hours == hour_last) begin
              hour_nxt = '0;
              tick_nxt = 1'b1;
            end else begin
              hour_nxt = hours + hour_num'(1);
            end
          end else begin
            min_nxt = minutes + min_num'(1);
          end
        end else begin
          sec_nxt = seconds + sec_num'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      seconds  <= '0;
      minutes  <= '0;
      hours    <= '0;
      day_tick <= 1'b0;
    end else begin
      seconds  <= sec_nxt;
      minutes  <= min_nxt;
      hours    <= hour_nxt;
      day_tick <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter: directed scenarios plus random state/button traffic,
// checked every cycle against a seconds-of-day reference model.
module tb_time_counter;

  logic       clk_1Hz = 1'b0;
  logic       rst_n;
  logic [2:0] state;
  logic       set_button;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic       day_tick;
  logic       setting;

  time_counter dut (
    .clk_1Hz    (clk_1Hz),
    .rst_n      (rst_n),
    .state      (state),
    .set_button (set_button),
    .seconds    (seconds),
    .minutes    (minutes),
    .hours      (hours),
    .day_tick   (day_tick),
    .setting    (setting)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  int total = 0;
  int bad   = 0;

  // Reference model: time of day as plain integers; bh[k] = button level sampled k+1 edges ago.
  int m_sec, m_min, m_hr;
  bit m_tick;
  bit bh [3];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, "_sec"},  32'(seconds),  32'(m_sec));
    check({tag, "_min"},  32'(minutes),  32'(m_min));
    check({tag, "_hour"}, 32'(hours),    32'(m_hr));
    check({tag, "_tick"}, 32'(day_tick), 32'(m_tick));
    check({tag, "_setting"}, 32'(setting), 32'((state >= 3'd2) && (state <= 3'd4)));
  endtask

  function automatic void model_reset();
    m_sec = 0; m_min = 0; m_hr = 0; m_tick = 0;
    for (int k = 0; k < 3; k++) bh[k] = 1'b1;
  endfunction

  // One clock: advance model for the edge about to happen, then compare on the falling edge.
  task automatic tick();
    bit press;
    int tod;
    press  = bh[2] && !bh[1];
    m_tick = 0;
    case (state)
      3'd2: if (press) m_sec = 0;
      3'd3: if (press) m_min = (m_min + 1) % 60;
      3'd4: if (press) m_hr  = (m_hr + 1) % 24;
      default: begin
        tod = m_hr * 3600 + m_min * 60 + m_sec + 1;
        if (tod == 86400) m_tick = 1;
        tod   = tod % 86400;
        m_hr  = tod / 3600;
        m_min = (tod / 60) % 60;
        m_sec = tod % 60;
      end
    endcase
    bh[2] = bh[1];
    bh[1] = bh[0];
    bh[0] = set_button;
    @(posedge clk_1Hz);
    @(negedge clk_1Hz);
    check_all("cyc");
  endtask

  task automatic press_btn(int hold);
    set_button = 1'b0;
    repeat (hold) tick();
    set_button = 1'b1;
    repeat (3) tick();
  endtask

  task automatic set_hour(int h);
    state = 3'd4;
    for (int i = 0; i < 24 && m_hr != h; i++) press_btn(1);
  endtask

  task automatic set_min(int mn);
    state = 3'd3;
    for (int i = 0; i < 60 && m_min != mn; i++) press_btn(1);
  endtask

  // Clear seconds, then let the clock run up to s (s < 60 so minutes do not carry).
  task automatic set_sec(int s);
    state = 3'd2;
    press_btn(1);
    state = 3'd0;
    repeat (s) tick();
  endtask

  // Async reset asserted mid low-phase; outputs must clear before any clock edge.
  task automatic do_reset(string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_sec"},  32'(seconds),  32'd0);
    check({tag, "_min"},  32'(minutes),  32'd0);
    check({tag, "_hour"}, 32'(hours),    32'd0);
    check({tag, "_tick"}, 32'(day_tick), 32'd0);
    model_reset();
    @(negedge clk_1Hz);
    rst_n = 1'b1;
  endtask

  initial begin
    int s0, m0, h0, tod0, tod1;
    rst_n = 1'b0;
    state = 3'd0;
    set_button = 1'b1;
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk_1Hz);
    rst_n = 1'b1;

    // Free run 61 s
    repeat (61) tick();
    check("run61_sec", 32'(seconds), 32'd1);
    check("run61_min", 32'(minutes), 32'd1);
    check("run61_hour", 32'(hours), 32'd0);

    // Preload 23:59:58 and roll over midnight
    set_hour(23);
    set_min(59);
    set_sec(58);
    check("pre_sec", 32'(seconds), 32'd58);
    check("pre_min", 32'(minutes), 32'd59);
    check("pre_hour", 32'(hours), 32'd23);
    tick();
    tick();
    check("mid_tick", 32'(day_tick), 32'd1);
    check("mid_tod", 32'({hours, minutes, seconds}), 32'd0);
    tick();
    check("mid_tick_next", 32'(day_tick), 32'd0);

    // Hour wrap in SET_HOUR: no day_tick, other fields frozen
    set_hour(23);
    s0 = m_sec; m0 = m_min;
    press_btn(1);
    check("hwrap_hour", 32'(hours), 32'd0);
    check("hwrap_sec", 32'(seconds), 32'(s0));
    check("hwrap_min", 32'(minutes), 32'(m0));

    // Minute wrap without carry, then clear seconds from 37
    h0 = m_hr;
    set_min(59);
    press_btn(1);
    check("mwrap_min", 32'(minutes), 32'd0);
    check("mwrap_hour", 32'(hours), 32'(h0));
    set_sec(37);
    check("sec37", 32'(seconds), 32'd37);
    state = 3'd2;
    press_btn(1);
    check("sec_clr", 32'(seconds), 32'd0);

    // Held button counts once; press while running is discarded
    state = 3'd3;
    m0 = m_min;
    press_btn(10);
    check("hold_min", 32'(minutes), 32'((m0 + 1) % 60));
    state = 3'd0;
    tod0 = hours * 3600 + minutes * 60 + seconds;
    press_btn(2);
    tod1 = hours * 3600 + minutes * 60 + seconds;
    check("run_press", 32'(tod1), 32'((tod0 + 5) % 86400));

    // Random state/button traffic
    repeat (300) begin
      state      = 3'($urandom_range(0, 7));
      set_button = 1'($urandom_range(0, 1));
      tick();
    end
    set_button = 1'b1;
    state = 3'd0;
    repeat (4) tick();

    // Reset at 12:34:56
    set_hour(12);
    set_min(34);
    set_sec(56);
    check("t1234_tod", 32'({hours, minutes, seconds}), 32'({5'd12, 6'd34, 6'd56}));
    do_reset("rst_mid");
    tick();
    check("rst_restart_sec", 32'(seconds), 32'd1);

    // Reset while day_tick is high
    set_hour(23);
    set_min(59);
    set_sec(59);
    tick();
    check("rst_tick_pre", 32'(day_tick), 32'd1);
    do_reset("rst_tick");
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
